// File: rtl/mem_map_pkg.sv
// ---------------------------------------------------------------------------
// mem_map_pkg
// Shared definitions for the memory responder:
//   - MMIO register offsets (byte offsets from the MMIO page base)
//   - DBG_STATUS bit positions
//   - decoded-target enum and the address decoder function
// ---------------------------------------------------------------------------
package mem_map_pkg;

    localparam logic [15:0] DBG_DATA_OFS   = 16'h0000;
    localparam logic [15:0] DBG_STATUS_OFS = 16'h0002;
    localparam logic [15:0] CYCLE_LO_OFS   = 16'h0004;
    localparam logic [15:0] CYCLE_HI_OFS   = 16'h0006;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;

    typedef enum logic [2:0] {
        TGT_RAM      = 3'd0,
        TGT_DBG_DATA = 3'd1,
        TGT_DBG_STAT = 3'd2,
        TGT_CYC_LO   = 3'd3,
        TGT_CYC_HI   = 3'd4,
        TGT_NONE     = 3'd5
    } mem_tgt_e;

    // Everything below the MMIO base is RAM; inside the page, byte bit 0 is
    // dropped so odd byte addresses hit the same register as the even one.
    function automatic mem_tgt_e decode_tgt(input logic [15:0] addr,
                                            input logic [15:0] base);
        logic [15:0] ofs;
        mem_tgt_e    tgt;
        ofs    = addr - base;
        ofs[0] = 1'b0;
        if (addr < base) begin
            tgt = TGT_RAM;
        end else begin
            case (ofs)
                DBG_DATA_OFS:   tgt = TGT_DBG_DATA;
                DBG_STATUS_OFS: tgt = TGT_DBG_STAT;
                CYCLE_LO_OFS:   tgt = TGT_CYC_LO;
                CYCLE_HI_OFS:   tgt = TGT_CYC_HI;
                default:        tgt = TGT_NONE;
            endcase
        end
        return tgt;
    endfunction

endpackage

// File: rtl/mem_responder_dbg_fifo.sv
// ---------------------------------------------------------------------------
// dbg_fifo
// Small synchronous FIFO holding debug output words.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset (empties the FIFO)
//   push      : write push_data (accepted if not full, or if full and
//               a valid pop happens in the same cycle)
//   push_data : word to enqueue
//   pop       : remove head word (ignored while empty)
//   head      : head-of-FIFO word, 0 while empty
//   empty     : no entries
//   full      : DEPTH entries
// Pointers carry one extra wrap bit so full and empty are distinguishable
// when the index bits match.
// ---------------------------------------------------------------------------
module dbg_fifo
    import mem_map_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [15:0] push_data,
    input  logic        pop,
    output logic [15:0] head,
    output logic        empty,
    output logic        full
);

    localparam int PW = $clog2(DEPTH);

    logic [15:0] mem_r [DEPTH];
    logic [PW:0] wr_ptr_r;
    logic [PW:0] rd_ptr_r;
    logic        pop_ok_s;
    logic        push_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]) &&
                       (wr_ptr_r[PW] != rd_ptr_r[PW]);
    assign pop_ok_s  = pop && !empty;
    // A pop frees a slot in the same edge, so a push into a full FIFO is
    // still accepted when it coincides with a valid pop.
    assign push_ok_s = push && (!full || pop_ok_s);
    assign head      = empty ? 16'h0000 : mem_r[rd_ptr_r[PW-1:0]];

    // Storage write; contents are not reset, validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[PW-1:0]] <= push_data;
        end
    end

    // Read/write pointer update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the core's 16-bit memory bus: word-organised
// synchronous RAM below MMIO_BASE plus a small MMIO page (debug FIFO with a
// valid/ready drain port, free-running 32-bit cycle counter).
//
// Ports:
//   clk           : rising-edge clock
//   reset         : asynchronous active-low reset
//   i_mem_addr    : byte address (bit 0 ignored)
//   i_mem_rd      : read strobe, data returned on o_mem_rddata one edge later
//   i_mem_wr      : write strobe, committed at the edge
//   i_mem_wrdata  : write data
//   o_mem_rddata  : registered read data, holds when no read
//   o_dbg_valid   : debug FIFO non-empty
//   o_dbg_data    : debug FIFO head word
//   i_dbg_ready   : downstream accepts the head word
//
// Build option: MEM_RESP_CYCLE_CNT_EN - when defined, the cycle counter and
// its HI shadow are built; otherwise CYCLE_LO/CYCLE_HI read as 0.
// ---------------------------------------------------------------------------
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int          RAM_WORDS  = 4096,
    parameter logic [15:0] MMIO_BASE  = 16'hF000,
    parameter int          FIFO_DEPTH = 8,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_mem_addr,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [15:0] i_mem_wrdata,
    output logic [15:0] o_mem_rddata,
    output logic        o_dbg_valid,
    output logic [15:0] o_dbg_data,
    input  logic        i_dbg_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);

    logic [15:0]       ram_r [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx_s;
    mem_tgt_e          tgt_s;
    logic [15:0]       rd_mux_s;
    logic [15:0]       status_s;
    logic [15:0]       cyc_lo_s;
    logic [15:0]       cyc_hi_s;
    logic              ram_we_s;
    logic              dbg_wr_s;
    logic              dbg_pop_s;
    logic              ovf_set_s;
    logic              ovf_clr_s;
    logic              ovf_r;
    logic              fifo_empty_s;
    logic              fifo_full_s;

    // Word index modulo RAM_WORDS: the RAM aliases throughout the space
    // below the MMIO page.
    assign ram_idx_s = i_mem_addr[RAM_AW:1];
    assign tgt_s     = decode_tgt(i_mem_addr, MMIO_BASE);
    assign ram_we_s  = i_mem_wr && (tgt_s == TGT_RAM);
    assign dbg_wr_s  = i_mem_wr && (tgt_s == TGT_DBG_DATA);
    assign dbg_pop_s = o_dbg_valid && i_dbg_ready;
    // A push into a full FIFO only overflows if no pop frees a slot.
    assign ovf_set_s = dbg_wr_s && fifo_full_s && !dbg_pop_s;
    assign ovf_clr_s = i_mem_wr && (tgt_s == TGT_DBG_STAT) && i_mem_wrdata[ST_OVF];
    assign o_dbg_valid = !fifo_empty_s;

    // RAM write port; no reset so the array maps onto memory macros.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= i_mem_wrdata;
        end
    end

    // Assemble DBG_STATUS from FIFO flags and the sticky overflow bit.
    always_comb begin
        status_s           = 16'h0000;
        status_s[ST_EMPTY] = fifo_empty_s;
        status_s[ST_FULL]  = fifo_full_s;
        status_s[ST_OVF]   = ovf_r;
    end

    // Read data select; the RAM value is the pre-edge content, which gives
    // read-before-write when a write hits the same word in the same cycle.
    always_comb begin
        rd_mux_s = 16'h0000;
        case (tgt_s)
            TGT_RAM:      rd_mux_s = ram_r[ram_idx_s];
            TGT_DBG_STAT: rd_mux_s = status_s;
            TGT_CYC_LO:   rd_mux_s = cyc_lo_s;
            TGT_CYC_HI:   rd_mux_s = cyc_hi_s;
            default:      rd_mux_s = 16'h0000;
        endcase
    end

    // Registered read data, updated only on a read strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_mem_rddata <= 16'h0000;
        end else if (i_mem_rd) begin
            o_mem_rddata <= rd_mux_s;
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
        end
    end

`ifdef MEM_RESP_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_r;
    logic [15:0] cyc_hi_r;

    // Free-running cycle counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_r <= 32'h0000_0000;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
        end
    end

    // Reading LO snapshots the upper half so a following HI read is coherent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_hi_r <= 16'h0000;
        end else if (i_mem_rd && (tgt_s == TGT_CYC_LO)) begin
            cyc_hi_r <= cycle_cnt_r[31:16];
        end
    end

    assign cyc_lo_s = cycle_cnt_r[15:0];
    assign cyc_hi_s = cyc_hi_r;
`else
    assign cyc_lo_s = 16'h0000;
    assign cyc_hi_s = 16'h0000;
`endif

    dbg_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_dbg_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (dbg_wr_s),
        .push_data (i_mem_wrdata),
        .pop       (dbg_pop_s),
        .head      (o_dbg_data),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

endmodule
